spi_master_mcs: RTL and testbench
=================================

SPI_MASTER_MCS -- requirements
Module: spi_master_mcs

Interface
REQ-001 The block SHALL have parameter SPI_DATA_WIDTH, default 32: maximum bits per transfer.
REQ-002 The block SHALL have parameter SPI_CLOCK_DIVIDER_WIDTH, default 5: width of the divider input.
REQ-003 The block SHALL have parameter CS_COUNT, default 4: number of chip-select lines; CS_SEL_WIDTH = max(1, clog2(CS_COUNT)); LEN_WIDTH = clog2(SPI_DATA_WIDTH+1).
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset: i_clock input 1 is the system clock; i_reset_n input 1 is the asynchronous active-low reset.
REQ-005 The block SHALL have i_valid input 1: transfer request.
REQ-006 The block SHALL have o_ready output 1: request accepted when i_valid & o_ready.
REQ-007 The block SHALL have i_data input SPI_DATA_WIDTH: TX word, right-justified.
REQ-008 The block SHALL have i_length input LEN_WIDTH: bits to transfer, range 1..SPI_DATA_WIDTH.
REQ-009 The block SHALL have i_cs_select input CS_SEL_WIDTH: target slave index.
REQ-010 The block SHALL have i_cs_hold input 1: keep CS asserted after this transfer.
REQ-011 The block SHALL have i_clock_polarity, input 1 (CPOL), and i_clock_phase, input 1 (CPHA).
REQ-012 The block SHALL have i_spi_clock_divider input SPI_CLOCK_DIVIDER_WIDTH: system cycles per SPI half-period.
REQ-013 The block SHALL have o_data output SPI_DATA_WIDTH (RX word, right-justified, upper bits 0), o_data_valid output 1 (one-cycle pulse) and o_busy output 1.
REQ-014 The block SHALL have o_spi_cs_n output CS_COUNT, o_spi_clock output 1, o_spi_mosi output 1 and i_spi_miso input 1.

Function
REQ-015 Accept SHALL latch data, length, cs_select, cs_hold, CPOL, CPHA and divider; later input changes SHALL NOT affect the transfer.
REQ-016 Half-period SHALL equal the divider value in system cycles; a divider of 0 SHALL be treated as 1.
REQ-017 The FSM SHALL have states IDLE, SETUP, SHIFT, HOLD, GAP.
REQ-018 IDLE: o_ready=1. On accept, go to SETUP, assert the selected o_spi_cs_n bit low and drive MOSI with bit length-1.
REQ-019 SETUP SHALL last one half-period with SCLK=CPOL, then go to SHIFT.
REQ-020 SHIFT SHALL produce 2*length SCLK edges, MSB first.
REQ-021 With CPHA=0, MISO SHALL be sampled on odd (leading) edges and MOSI updated on even (trailing) edges.
REQ-022 With CPHA=1, MOSI SHALL be updated on leading edges and MISO sampled on trailing edges.
REQ-023 After the last edge, SCLK SHALL rest at CPOL and the FSM SHALL go to HOLD for one half-period.
REQ-024 At HOLD exit, o_data SHALL be updated and o_data_valid SHALL pulse for exactly one cycle.
REQ-025 If cs_hold=0 at HOLD exit, CS SHALL be deasserted and the FSM SHALL go to GAP: one half-period with all CS high, then IDLE.
REQ-026 If cs_hold=1 at HOLD exit, CS SHALL remain low and the FSM SHALL go to IDLE; o_ready=1.
REQ-027 A request accepted with the same cs_select while CS is held SHALL go directly to SETUP without deasserting CS.
REQ-028 A request accepted with a different cs_select while CS is held SHALL first deassert the held CS for one GAP half-period.
REQ-029 o_busy SHALL be 1 in every state except IDLE; o_ready SHALL equal (state==IDLE).
REQ-030 Requests while busy SHALL be ignored (not accepted, no side effects).
REQ-031 A length of 0 or greater than SPI_DATA_WIDTH SHALL be treated as SPI_DATA_WIDTH.
REQ-032 A cs_select of CS_COUNT or more SHALL run the transfer with all CS lines high.
REQ-033 MOSI SHALL hold its last bit after the transfer until the next accept.

Reset
REQ-034 Asserting i_reset_n low SHALL immediately, including mid-transfer, force: state IDLE, o_spi_cs_n all 1, o_spi_clock 0, o_spi_mosi 0, o_data 0, o_data_valid 0, o_busy 0, o_ready 0 while asserted.
REQ-035 The first accept SHALL be possible in the cycle after reset release.

Structure
REQ-036 Package spi_pkg SHALL hold the FSM state enum, SPI_MODE constants (MODE0..MODE3 as {CPOL,CPHA}) and default parameter constants.
REQ-037 Sub-module spi_clock_gen SHALL provide the half-period counter and leading/trailing edge strobes.
REQ-038 Shifting, CS management and handshake logic SHALL reside in spi_master_mcs.

Verification
REQ-039 Mode 0, divider 2, length 8, data 0xA5, cs 1, MISO looped to MOSI -> o_spi_cs_n=4'b1101 during transfer, 16 SCLK edges of 2 cycles each, o_data=0x000000A5, one o_data_valid pulse.
REQ-040 Modes 1/2/3, length 32, data 0xDEADBEEF, slave model returns 0x12345678 -> o_data=0x12345678 in every mode; SCLK idles at CPOL.
REQ-041 Two length-16 transfers to cs 0 with cs_hold=1 then 0 -> cs_n[0] low continuously across both, then high after GAP.
REQ-042 cs_hold=1 on cs 2, next request to cs 3 -> cs_n goes 4'b1011, then 4'b1111 for one half-period, then 4'b0111.
REQ-043 Length 0 and divider 0 -> 32-bit transfer with 1-cycle half-periods; cs_select 5 -> all CS high, o_data_valid still pulses.
REQ-044 Reset pulsed at bit 10 of a 32-bit transfer -> all outputs at reset values the same cycle, no o_data_valid, a new transfer completes normally.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared FSM state type, SPI mode encodings and default parameter values
// for the multi-chip-select SPI master.
package spi_pkg;
    localparam int SPI_DATA_WIDTH_DEF          = 32;
    localparam int SPI_CLOCK_DIVIDER_WIDTH_DEF = 5;
    localparam int CS_COUNT_DEF                = 4;

    // Modes encoded as {CPOL, CPHA}
    localparam logic [1:0] SPI_MODE0 = 2'b00;
    localparam logic [1:0] SPI_MODE1 = 2'b01;
    localparam logic [1:0] SPI_MODE2 = 2'b10;
    localparam logic [1:0] SPI_MODE3 = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } spi_state_e;
endpackage

// File: rtl/spi_clock_gen.sv
// Half-period timer for the SPI master. Every tick ends one half-period;
// inside the edge window, ticks alternate between leading and trailing strobes.
module spi_clock_gen
    import spi_pkg::*;
#(
    parameter int DIV_WIDTH = SPI_CLOCK_DIVIDER_WIDTH_DEF
) (
    input  logic                 i_clock,
    input  logic                 i_reset_n,
    input  logic                 i_run,
    input  logic                 i_edge_window,
    input  logic [DIV_WIDTH-1:0] i_divider,
    output logic                 o_tick,
    output logic                 o_lead,
    output logic                 o_trail
);
    logic [DIV_WIDTH-1:0] cnt_q, cnt_d, half_m1;
    logic                 lead_next_q, lead_next_d;

    always_comb begin
        // A divider of zero behaves like one
        half_m1     = (i_divider == '0) ? '0 : i_divider - DIV_WIDTH'(1);
        o_tick      = i_run && (cnt_q == half_m1);
        o_lead      = o_tick && i_edge_window && lead_next_q;
        o_trail     = o_tick && i_edge_window && !lead_next_q;
        cnt_d       = (!i_run || o_tick) ? '0 : cnt_q + DIV_WIDTH'(1);
        lead_next_d = lead_next_q;
        if (!i_edge_window)
            lead_next_d = 1'b1;
        else if (o_tick)
            lead_next_d = !lead_next_q;
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cnt_q       <= '0;
            lead_next_q <= 1'b1;
        end else begin
            cnt_q       <= cnt_d;
            lead_next_q <= lead_next_d;
        end
    end
endmodule

// File: rtl/spi_master_mcs.sv
// SPI master with several chip selects, per-transfer mode/length/divider and
// optional CS hold between transfers to the same slave.
module spi_master_mcs
    import spi_pkg::*;
#(
    parameter int  SPI_DATA_WIDTH          = SPI_DATA_WIDTH_DEF,
    parameter int  SPI_CLOCK_DIVIDER_WIDTH = SPI_CLOCK_DIVIDER_WIDTH_DEF,
    parameter int  CS_COUNT                = CS_COUNT_DEF,
    localparam int CS_SEL_WIDTH            = (CS_COUNT > 1) ? $clog2(CS_COUNT) : 1,
    localparam int LEN_WIDTH               = $clog2(SPI_DATA_WIDTH + 1)
) (
    input  logic                               i_clock,
    input  logic                               i_reset_n,
    input  logic                               i_valid,
    output logic                               o_ready,
    input  logic [SPI_DATA_WIDTH-1:0]          i_data,
    input  logic [LEN_WIDTH-1:0]               i_length,
    input  logic [CS_SEL_WIDTH-1:0]            i_cs_select,
    input  logic                               i_cs_hold,
    input  logic                               i_clock_polarity,
    input  logic                               i_clock_phase,
    input  logic [SPI_CLOCK_DIVIDER_WIDTH-1:0] i_spi_clock_divider,
    output logic [SPI_DATA_WIDTH-1:0]          o_data,
    output logic                               o_data_valid,
    output logic                               o_busy,
    output logic [CS_COUNT-1:0]                o_spi_cs_n,
    output logic                               o_spi_clock,
    output logic                               o_spi_mosi,
    input  logic                               i_spi_miso
);
    localparam int W = SPI_DATA_WIDTH;

    spi_state_e                         state_q, state_d;
    logic [W-1:0]                       tx_q, tx_d, rx_q, rx_d, data_q, data_d;
    logic [LEN_WIDTH-1:0]               idx_q, idx_d, len_eff;
    logic [CS_SEL_WIDTH-1:0]            sel_q, sel_d;
    logic                               hold_q, hold_d, cpol_q, cpol_d, cpha_q, cpha_d;
    logic [SPI_CLOCK_DIVIDER_WIDTH-1:0] div_q, div_d;
    logic [CS_COUNT-1:0]                cs_n_q, cs_n_d;
    logic                               sclk_q, sclk_d, mosi_q, mosi_d, dv_q, dv_d;
    logic                               cs_held_q, cs_held_d, pend_q, pend_d;
    logic [W-1:0]                       acc_sh, tx_cur, tx_nxt;
    logic                               tick, lead, trail;

    // Out-of-range selects decode to all lines high
    function automatic logic [CS_COUNT-1:0] cs_decode(input logic [CS_SEL_WIDTH-1:0] sel);
        cs_decode = '1;
        for (int i = 0; i < CS_COUNT; i++)
            if (sel == CS_SEL_WIDTH'(i)) cs_decode[i] = 1'b0;
    endfunction

    spi_clock_gen #(.DIV_WIDTH(SPI_CLOCK_DIVIDER_WIDTH)) u_clk_gen (
        .i_clock      (i_clock),
        .i_reset_n    (i_reset_n),
        .i_run        (state_q != IDLE),
        .i_edge_window(state_q == SETUP || state_q == SHIFT),
        .i_divider    (div_q),
        .o_tick       (tick),
        .o_lead       (lead),
        .o_trail      (trail)
    );

    always_comb begin
        state_d   = state_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        data_d    = data_q;
        idx_d     = idx_q;
        sel_d     = sel_q;
        hold_d    = hold_q;
        cpol_d    = cpol_q;
        cpha_d    = cpha_q;
        div_d     = div_q;
        cs_n_d    = cs_n_q;
        sclk_d    = sclk_q;
        mosi_d    = mosi_q;
        dv_d      = 1'b0;
        cs_held_d = cs_held_q;
        pend_d    = pend_q;

        if (i_length == '0 || i_length > LEN_WIDTH'(W))
            len_eff = LEN_WIDTH'(W);
        else
            len_eff = i_length;
        acc_sh = i_data >> (len_eff - LEN_WIDTH'(1));
        tx_cur = tx_q >> idx_q;
        tx_nxt = tx_q >> (idx_q - LEN_WIDTH'(1));

        case (state_q)
            IDLE: if (i_valid) begin
                tx_d   = i_data;
                rx_d   = '0;
                idx_d  = len_eff - LEN_WIDTH'(1);
                sel_d  = i_cs_select;
                hold_d = i_cs_hold;
                cpol_d = i_clock_polarity;
                cpha_d = i_clock_phase;
                div_d  = i_spi_clock_divider;
                sclk_d = i_clock_polarity;
                mosi_d = acc_sh[0];
                // Switching slaves releases the held line for one gap first
                if (cs_held_q && i_cs_select != sel_q) begin
                    cs_n_d    = '1;
                    cs_held_d = 1'b0;
                    pend_d    = 1'b1;
                    state_d   = GAP;
                end else begin
                    cs_n_d  = cs_decode(i_cs_select);
                    state_d = SETUP;
                end
            end
            SETUP: if (tick) state_d = SHIFT;
            SHIFT: if (trail && idx_q == '0) state_d = HOLD;
            HOLD: if (tick) begin
                data_d = rx_q;
                dv_d   = 1'b1;
                if (hold_q) begin
                    cs_held_d = ~&cs_n_q;
                    state_d   = IDLE;
                end else begin
                    cs_n_d    = '1;
                    cs_held_d = 1'b0;
                    state_d   = GAP;
                end
            end
            GAP: if (tick) begin
                if (pend_q) begin
                    pend_d  = 1'b0;
                    cs_n_d  = cs_decode(sel_q);
                    state_d = SETUP;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (lead || trail) sclk_d = !sclk_q;
        if (lead) begin
            if (cpha_q) mosi_d = tx_cur[0];
            else        rx_d   = {rx_q[W-2:0], i_spi_miso};
        end
        // The final bit stays on MOSI once the last trailing edge has passed
        if (trail) begin
            if (cpha_q)              rx_d   = {rx_q[W-2:0], i_spi_miso};
            else if (idx_q != '0)    mosi_d = tx_nxt[0];
            if (idx_q != '0)         idx_d  = idx_q - LEN_WIDTH'(1);
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q   <= IDLE;
            tx_q      <= '0;
            rx_q      <= '0;
            data_q    <= '0;
            idx_q     <= '0;
            sel_q     <= '0;
            hold_q    <= 1'b0;
            cpol_q    <= 1'b0;
            cpha_q    <= 1'b0;
            div_q     <= '0;
            cs_n_q    <= '1;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            dv_q      <= 1'b0;
            cs_held_q <= 1'b0;
            pend_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            data_q    <= data_d;
            idx_q     <= idx_d;
            sel_q     <= sel_d;
            hold_q    <= hold_d;
            cpol_q    <= cpol_d;
            cpha_q    <= cpha_d;
            div_q     <= div_d;
            cs_n_q    <= cs_n_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
            dv_q      <= dv_d;
            cs_held_q <= cs_held_d;
            pend_q    <= pend_d;
        end
    end

    assign o_ready      = (state_q == IDLE) && i_reset_n;
    assign o_busy       = (state_q != IDLE);
    assign o_data       = data_q;
    assign o_data_valid = dv_q;
    assign o_spi_cs_n   = cs_n_q;
    assign o_spi_clock  = sclk_q;
    assign o_spi_mosi   = mosi_q;
endmodule

// File: tb/tb_spi_master_mcs.sv
// Scoreboard bench for spi_master_mcs: a 4-CS instance for most scenarios and
// a 5-CS instance for the out-of-range select / length 0 / divider 0 case.
module tb_spi_master_mcs;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        a_valid = 1'b0, b_valid = 1'b0;
    logic [31:0] data;
    logic [5:0]  len;
    logic [2:0]  sel;
    logic        hold, cpol, cpha;
    logic [4:0]  div;

    logic        a_ready, a_dv, a_busy, a_sclk, a_mosi, a_miso;
    logic [31:0] a_data;
    logic [3:0]  a_cs_n;
    logic        b_ready, b_dv, b_busy, b_sclk, b_mosi;
    logic [31:0] b_data;
    logic [4:0]  b_cs_n;

    logic        loopback = 1'b1;
    logic        slv_miso = 1'b0, slv_cpol = 1'b0, slv_cpha = 1'b0;
    logic [31:0] slv_word = '0;
    int          slv_idx = 0;
    assign a_miso = loopback ? a_mosi : slv_miso;

    spi_master_mcs u_a (
        .i_clock(clk), .i_reset_n(rst_n), .i_valid(a_valid), .o_ready(a_ready),
        .i_data(data), .i_length(len), .i_cs_select(sel[1:0]), .i_cs_hold(hold),
        .i_clock_polarity(cpol), .i_clock_phase(cpha), .i_spi_clock_divider(div),
        .o_data(a_data), .o_data_valid(a_dv), .o_busy(a_busy), .o_spi_cs_n(a_cs_n),
        .o_spi_clock(a_sclk), .o_spi_mosi(a_mosi), .i_spi_miso(a_miso)
    );

    spi_master_mcs #(.CS_COUNT(5)) u_b (
        .i_clock(clk), .i_reset_n(rst_n), .i_valid(b_valid), .o_ready(b_ready),
        .i_data(data), .i_length(len), .i_cs_select(sel), .i_cs_hold(hold),
        .i_clock_polarity(cpol), .i_clock_phase(cpha), .i_spi_clock_divider(div),
        .o_data(b_data), .o_data_valid(b_dv), .o_busy(b_busy), .o_spi_cs_n(b_cs_n),
        .o_spi_clock(b_sclk), .o_spi_mosi(b_mosi), .i_spi_miso(b_mosi)
    );

    typedef struct {
        bit          dut;
        logic [31:0] data;
        int          edges;
        logic [4:0]  cs;
        int          hp;
        logic        cpol;
    } exp_t;
    exp_t q[$];
    exp_t e;

    int n_chk = 0, n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: timed out, %0d responses outstanding", name, q.size());
    endtask

    // Slave model for the 4-CS instance: drives MISO per mode, MSB first
    always @(a_sclk) begin
        if (a_sclk !== slv_cpol) begin
            if (slv_cpha) begin
                if (slv_idx >= 0) slv_miso = slv_word[slv_idx[4:0]];
                slv_idx--;
            end
        end else if (!slv_cpha) begin
            slv_idx--;
            if (slv_idx >= 0) slv_miso = slv_word[slv_idx[4:0]];
        end
    end

    // Monitor: tracks SCLK edges, spacing and CS per instance; checks at o_data_valid
    int          edges[2], since[2], hmin[2], hmax[2];
    logic        prev_s[2], prev_b[2];
    logic [4:0]  cs_first[2];
    bit          cs_bad[2];
    logic        m_s, m_dv, m_b, m_cpol;
    logic [4:0]  m_cs;
    logic [31:0] m_dat;
    int          cyc = 0;

    always @(negedge clk) begin
        cyc++;
        for (int d = 0; d < 2; d++) begin
            m_s   = d ? b_sclk : a_sclk;
            m_dv  = d ? b_dv : a_dv;
            m_b   = d ? b_busy : a_busy;
            m_cs  = d ? b_cs_n : {1'b1, a_cs_n};
            m_dat = d ? b_data : a_data;
            if (!rst_n) begin
                edges[d] = 0; since[d] = 0; hmin[d] = 1000; hmax[d] = 0;
                cs_bad[d] = 0; cs_first[d] = '1; prev_b[d] = 1'b0; prev_s[d] = m_s;
            end else begin
                since[d]++;
                if (m_s !== prev_s[d] && m_b && prev_b[d]) begin
                    if (edges[d] > 0) begin
                        if (since[d] < hmin[d]) hmin[d] = since[d];
                        if (since[d] > hmax[d]) hmax[d] = since[d];
                        if (m_cs !== cs_first[d]) cs_bad[d] = 1;
                    end else begin
                        cs_first[d] = m_cs;
                    end
                    edges[d]++;
                    since[d] = 0;
                end
                prev_s[d] = m_s;
                prev_b[d] = m_b;
                if (m_dv) begin
                    if (q.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL unexpected_dv: dut %0d data %0h with nothing expected", d, m_dat);
                    end else begin
                        e = q.pop_front();
                        m_cpol = m_s;
                        check("dv_dut", 64'(d), 64'(e.dut));
                        check("rx_data", 64'(m_dat), 64'(e.data));
                        check("sclk_edges", 64'(edges[d]), 64'(e.edges));
                        check("cs_during_shift", 64'(cs_first[d]), 64'(e.cs));
                        check("cs_stable", 64'(cs_bad[d]), 64'(0));
                        check("half_min", 64'(hmin[d]), 64'(e.hp));
                        check("half_max", 64'(hmax[d]), 64'(e.hp));
                        check("sclk_rest", 64'(m_cpol), 64'(e.cpol));
                    end
                    edges[d] = 0; hmin[d] = 1000; hmax[d] = 0; cs_bad[d] = 0;
                end
            end
        end
    end

    // CS transition log for the slave-switch scenario
    typedef struct { logic [3:0] v; int c; } log_t;
    log_t       cs_log[$];
    logic       log_en = 1'b0;
    logic [3:0] cs_last = 4'hF;
    always @(negedge clk) begin
        if (log_en && a_cs_n !== cs_last) cs_log.push_back('{a_cs_n, cyc});
        cs_last = a_cs_n;
    end

    task automatic send(input bit dut_b, input logic [31:0] d, input logic [5:0] l,
                        input logic [2:0] s, input bit h, input logic [1:0] mode,
                        input logic [4:0] dv, input bit push, input logic [31:0] exp_data,
                        input int exp_edges, input logic [4:0] exp_cs, input int exp_hp);
        int t = 0;
        @(negedge clk);
        while (!(dut_b ? b_ready : a_ready) && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 2000) timeout("send_ready");
        data = d; len = l; sel = s; hold = h; cpol = mode[1]; cpha = mode[0]; div = dv;
        if (dut_b) b_valid = 1'b1; else a_valid = 1'b1;
        if (push) q.push_back('{dut_b, exp_data, exp_edges, exp_cs, exp_hp, mode[1]});
        @(posedge clk);
        #1;
        a_valid = 1'b0; b_valid = 1'b0;
        // Scramble inputs: the accepted transfer must not notice
        data = ~d; len = 6'd3; sel = s ^ 3'd1; hold = ~h; cpol = ~mode[1]; cpha = ~mode[0]; div = 5'd7;
    endtask

    task automatic wait_done();
        int t = 0;
        while ((q.size() != 0 || !a_ready || !b_ready) && t < 5000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 5000) timeout("wait_done");
    endtask

    int t, high;

    initial begin
        data = '0; len = '0; sel = '0; hold = 0; cpol = 0; cpha = 0; div = '0;
        repeat (3) @(negedge clk);
        check("rst_cs_n", 64'(a_cs_n), 64'hF);
        check("rst_sclk", 64'(a_sclk), 64'(0));
        check("rst_ready", 64'(a_ready), 64'(0));
        check("rst_busy", 64'(a_busy), 64'(0));
        rst_n = 1'b1;

        // Mode 0 loopback on CS1, with ignored requests while busy
        send(0, 32'hA5, 6'd8, 3'd1, 0, 2'b00, 5'd2, 1, 32'hA5, 16, 5'b11101, 2);
        a_valid = 1'b1;
        repeat (6) @(negedge clk);
        a_valid = 1'b0;
        wait_done();

        // Modes 1..3 against the slave model
        loopback = 1'b0;
        for (int m = 1; m < 4; m++) begin
            send(0, 32'hDEADBEEF, 6'd32, 3'd0, 0, 2'(m), 5'd3, 1, 32'h12345678, 64, 5'b11110, 3);
            slv_word = 32'h12345678; slv_cpol = m[1]; slv_cpha = m[0]; slv_idx = 31;
            if (!slv_cpha) slv_miso = slv_word[31];
            wait_done();
        end
        loopback = 1'b1;

        // Length 33 clamps to 32
        send(0, 32'h0F1E2D3C, 6'd33, 3'd2, 0, 2'b00, 5'd1, 1, 32'h0F1E2D3C, 64, 5'b11011, 1);
        wait_done();

        // Held CS0 across two transfers
        send(0, 32'h1234, 6'd16, 3'd0, 1, 2'b00, 5'd2, 1, 32'h1234, 32, 5'b11110, 2);
        high = 0; t = 0;
        while (!a_ready && t < 2000) begin @(negedge clk); if (a_cs_n[0]) high++; t++; end
        if (t >= 2000) timeout("hold_first");
        check("cs_held_idle", 64'(a_cs_n), 64'hE);
        send(0, 32'hBEEF, 6'd16, 3'd0, 0, 2'b00, 5'd2, 1, 32'hBEEF, 32, 5'b11110, 2);
        t = 0;
        while (!a_dv && t < 2000) begin @(negedge clk); if (!a_dv && a_cs_n[0]) high++; t++; end
        if (t >= 2000) timeout("hold_second");
        check("cs0_continuous", 64'(high), 64'(0));
        check("gap_cs_n", 64'(a_cs_n), 64'hF);
        check("gap_busy", 64'(a_busy), 64'(1));
        @(negedge clk);
        check("gap_busy2", 64'(a_busy), 64'(1));
        @(negedge clk);
        check("gap_done_ready", 64'(a_ready), 64'(1));
        wait_done();

        // Held CS2, then switch to CS3
        cs_log.delete();
        log_en = 1'b1;
        send(0, 32'h3C, 6'd8, 3'd2, 1, 2'b00, 5'd2, 1, 32'h3C, 16, 5'b11011, 2);
        send(0, 32'hC3, 6'd8, 3'd3, 0, 2'b00, 5'd2, 1, 32'hC3, 16, 5'b10111, 2);
        wait_done();
        log_en = 1'b0;
        check("cs_log_len", 64'(cs_log.size()), 64'(4));
        if (cs_log.size() >= 4) begin
            check("cs_log0", 64'(cs_log[0].v), 64'hB);
            check("cs_log1", 64'(cs_log[1].v), 64'hF);
            check("cs_log2", 64'(cs_log[2].v), 64'h7);
            check("cs_log3", 64'(cs_log[3].v), 64'hF);
            check("cs_switch_gap", 64'(cs_log[2].c - cs_log[1].c), 64'(2));
        end

        // Length 0, divider 0, select out of range on the 5-CS instance
        send(1, 32'h89ABCDEF, 6'd0, 3'd5, 0, 2'b00, 5'd0, 1, 32'h89ABCDEF, 64, 5'b11111, 1);
        wait_done();

        // Reset in the middle of a transfer
        send(0, 32'hFFFFFFFF, 6'd32, 3'd1, 0, 2'b10, 5'd2, 0, 32'h0, 0, 5'b0, 0);
        t = 0;
        while (edges[0] < 20 && t < 1000) begin @(negedge clk); t++; end
        if (t >= 1000) timeout("reset_wait");
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_cs_n", 64'(a_cs_n), 64'hF);
        check("mid_rst_sclk", 64'(a_sclk), 64'(0));
        check("mid_rst_mosi", 64'(a_mosi), 64'(0));
        check("mid_rst_data", 64'(a_data), 64'(0));
        check("mid_rst_dv", 64'(a_dv), 64'(0));
        check("mid_rst_busy", 64'(a_busy), 64'(0));
        check("mid_rst_ready", 64'(a_ready), 64'(0));
        repeat (2) @(negedge clk);
        data = 32'h5A; len = 6'd8; sel = 3'd1; hold = 0; cpol = 0; cpha = 0; div = 5'd2;
        a_valid = 1'b1;
        q.push_back('{1'b0, 32'h5A, 16, 5'b11101, 2, 1'b0});
        rst_n = 1'b1;
        #1;
        check("ready_after_release", 64'(a_ready), 64'(1));
        @(posedge clk);
        #1 a_valid = 1'b0;
        wait_done();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
